pi_timing_generator: RTL and testbench
======================================

// Module: pi_timing_generator
// PURPOSE
// Generates interlaced 720x576 (PAL, 864x625 @ 13.5 MHz dot rate) sync and display-enable timing,
// with active-low syncs, for the FPGA-side video source.
// Field identity is encoded by the hSync level at the vSync falling edge: low = odd field, high = even field.
// Also outputs position counters, so the timing can be loop-back checked against the Pi-side pixel/line trackers.
// PARAMETERS
// H_TOTAL      864  dots per line (dot counter 0..H_TOTAL-1)
// H_SYNC       64   hSync low for dots 0..H_SYNC-1
// H_ACT_START  132  first active dot
// H_ACTIVE     720  active dots per line
// V_TOTAL      625  lines per frame (frame line counter 0..V_TOTAL-1)
// V_SYNC       3    vSync low duration, in whole lines (V_SYNC*H_TOTAL dot ticks)
// ODD_ACT      23   first active frame line, odd field
// EVEN_ACT     335  first active frame line, even field
// V_ACTIVE     288  active lines per field
// PORTS
// pixelClockX6     in   1   system clock, 6x dot rate
// nReset           in   1   asynchronous active-low reset
// pixelClockPhase  in   3   dot phase 0..5; a "tick" is a cycle with pixelClockPhase==0
// hSync            out  1   horizontal sync, active low
// vSync            out  1   vertical sync, active low
// displayEnabled   out  1   high during active dots of active lines
// isFieldOdd       out  1   1 = odd field, 0 = even field
// fieldLine        out  10  active line index within field, 0..287; 0 outside active lines
// fieldLineDot     out  10  active dot index, 0..719; 0 when displayEnabled=0
// BEHAVIOUR
// - Reset (async): dot=0, line=0, hSync=1, vSync=1, displayEnabled=0, isFieldOdd=0, fieldLine=0, fieldLineDot=0.
// - State changes only on ticks; non-tick cycles hold all registers.
// - Each tick: all outputs are registered from a decode of the current (line,dot); then the counters advance.
//   Latency: outputs reflect the position one tick earlier. The first tick after reset outputs the decode of (0,0).
// - Counter advance: dot++. At dot==H_TOTAL-1: dot=0 and line++. At (V_TOTAL-1, H_TOTAL-1): wrap to (0,0).
// - hSync = 0 iff dot < H_SYNC, on every line, including vSync lines (no equalising pulses).
// - Odd-field vSync: 0 from (0,0) up to, but not including, (V_SYNC,0).
// - Even-field vSync: 0 from (312,432) up to, but not including, (312+V_SYNC,432).
// - Resulting edge alignment:
//   - odd-field vSync fall coincides with the hSync fall (hSync=0);
//   - even-field vSync fall is at mid-line (hSync=1).
// - isFieldOdd = 1 for (line<312) or (line==312 and dot<432); otherwise 0.
//   It changes on the same tick as the vSync fall.
// - Active line: ODD_ACT <= line < ODD_ACT+V_ACTIVE, or EVEN_ACT <= line < EVEN_ACT+V_ACTIVE.
//   Active dot: H_ACT_START <= dot < H_ACT_START+H_ACTIVE.
// - displayEnabled = active line AND active dot.
//   - fieldLine = line-ODD_ACT or line-EVEN_ACT on active lines, else 0.
//   - fieldLineDot = dot-H_ACT_START while displayEnabled, else 0.
// - Widths:
//   - dot and line counters are 10 bits;
//   - all comparisons and subtractions are 10-bit unsigned; parameter values guarantee no underflow.
// - Reset asserted mid-line or mid-field: immediate return to reset values.
//   Timing restarts from (0,0) on the first tick after release; no partial-field recovery.
// - pixelClockPhase values 6/7 never occur; they are treated as non-tick.
// TESTING
// 1. nReset low for 20 cycles -> hSync=1, vSync=1, displayEnabled=0, isFieldOdd=0.
//    Release -> on the first tick: hSync=0, vSync=0, isFieldOdd=1.
// 2. Free-run one line -> hSync low for exactly 64 ticks, period 864 ticks.
//    displayEnabled high 720 ticks, rising 132 ticks after the hSync fall; fieldLineDot runs 0..719.
// 3. Odd vSync fall: sample hSync=0 -> vSync low for 2592 ticks.
//    Even vSync fall occurs 312*864+432 ticks after the odd fall, with hSync=1, and isFieldOdd goes 0 on that tick.
// 4. One full frame -> 288 displayEnabled lines per field.
//    First active line is 23 lines after the odd vSync fall; fieldLine runs 0..287 in each field.
//    Frame period is 540000 ticks.
// 5. Hold pixelClockPhase=3 for 200 cycles mid-line -> no output changes.
//    Then assert nReset mid-field -> reset values immediately, restart at (0,0).
// 6. Loop hSync/vSync/displayEnabled into the Pi tracker -> tracker isFieldOdd matches this block.
//    Tracker fieldLineDot matches within one tick; frameLine covers all of 0..575 once per frame.

Source files
------------

// File: rtl/pi_timing_generator.sv
// Interlaced PAL (864x625) sync / display-enable generator for the FPGA-side video source.
// Outputs are a registered decode of the dot/line position, updated once per dot tick.
module pi_timing_generator #(
    parameter int H_TOTAL     = 864,
    parameter int H_SYNC      = 64,
    parameter int H_ACT_START = 132,
    parameter int H_ACTIVE    = 720,
    parameter int V_TOTAL     = 625,
    parameter int V_SYNC      = 3,
    parameter int ODD_ACT     = 23,
    parameter int EVEN_ACT    = 335,
    parameter int V_ACTIVE    = 288
) (
    input  logic       pixelClockX6,
    input  logic       nReset,
    input  logic [2:0] pixelClockPhase,
    output logic       hSync,
    output logic       vSync,
    output logic       displayEnabled,
    output logic       isFieldOdd,
    output logic [9:0] fieldLine,
    output logic [9:0] fieldLineDot
);

    localparam logic [9:0] hLast         = 10'(H_TOTAL - 1);
    localparam logic [9:0] vLast         = 10'(V_TOTAL - 1);
    localparam logic [9:0] hSyncEnd      = 10'(H_SYNC);
    localparam logic [9:0] hActStart     = 10'(H_ACT_START);
    localparam logic [9:0] hActEnd       = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0] vSyncLines    = 10'(V_SYNC);
    localparam logic [9:0] evenVsLine    = 10'(V_TOTAL / 2);
    localparam logic [9:0] evenVsDot     = 10'(H_TOTAL / 2);
    localparam logic [9:0] evenVsEndLine = 10'(V_TOTAL / 2 + V_SYNC);
    localparam logic [9:0] oddActStart   = 10'(ODD_ACT);
    localparam logic [9:0] oddActEnd     = 10'(ODD_ACT + V_ACTIVE);
    localparam logic [9:0] evenActStart  = 10'(EVEN_ACT);
    localparam logic [9:0] evenActEnd    = 10'(EVEN_ACT + V_ACTIVE);

    logic [9:0] dot;
    logic [9:0] line;
    logic       tick;

    logic       decHSync;
    logic       decVSync;
    logic       decFieldOdd;
    logic       decDisplay;
    logic [9:0] decFieldLine;
    logic [9:0] decFieldLineDot;
    logic       oddVsActive;
    logic       evenVsActive;
    logic       oddLineActive;
    logic       evenLineActive;
    logic       dotActive;

    assign tick = (pixelClockPhase == 3'd0);

    // The even-field vSync window starts and ends at mid-line, half a line after the odd one.
    always_comb begin
        decHSync        = (dot >= hSyncEnd);
        oddVsActive     = (line < vSyncLines);
        evenVsActive    = ((line == evenVsLine) && (dot >= evenVsDot)) ||
                          ((line > evenVsLine) && (line < evenVsEndLine)) ||
                          ((line == evenVsEndLine) && (dot < evenVsDot));
        decVSync        = !(oddVsActive || evenVsActive);
        decFieldOdd     = (line < evenVsLine) || ((line == evenVsLine) && (dot < evenVsDot));
        oddLineActive   = (line >= oddActStart) && (line < oddActEnd);
        evenLineActive  = (line >= evenActStart) && (line < evenActEnd);
        dotActive       = (dot >= hActStart) && (dot < hActEnd);
        decFieldLine    = 10'd0;
        if (oddLineActive) begin
            decFieldLine = line - oddActStart;
        end else if (evenLineActive) begin
            decFieldLine = line - evenActStart;
        end
        decDisplay      = (oddLineActive || evenLineActive) && dotActive;
        decFieldLineDot = decDisplay ? (dot - hActStart) : 10'd0;
    end

    // Outputs capture the decode of the current position, then the position advances.
    always_ff @(posedge pixelClockX6 or negedge nReset) begin
        if (!nReset) begin
            dot            <= 10'd0;
            line           <= 10'd0;
            hSync          <= 1'b1;
            vSync          <= 1'b1;
            displayEnabled <= 1'b0;
            isFieldOdd     <= 1'b0;
            fieldLine      <= 10'd0;
            fieldLineDot   <= 10'd0;
        end else if (tick) begin
            hSync          <= decHSync;
            vSync          <= decVSync;
            displayEnabled <= decDisplay;
            isFieldOdd     <= decFieldOdd;
            fieldLine      <= decFieldLine;
            fieldLineDot   <= decFieldLineDot;
            if (dot == hLast) begin
                dot <= 10'd0;
                if (line == vLast) begin
                    line <= 10'd0;
                end else begin
                    line <= line + 10'd1;
                end
            end else begin
                dot <= dot + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_pi_timing_generator.sv
// Bench for pi_timing_generator: a full PAL instance plus a scaled-down instance for whole-frame
// behaviour, both checked every cycle against a position-from-tick-count reference model.
module tb_pi_timing_generator;

    typedef struct packed {
        int hTot;
        int hSync;
        int hAct;
        int hActN;
        int vTot;
        int vSync;
        int oddAct;
        int evenAct;
        int vActN;
        int evenLine;
        int evenDot;
    } timingT;

    typedef struct packed {
        logic [2:0]  phase;
        logic [23:0] expFull;
    } vectorT;

    localparam logic [23:0] RESET_VALUE = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
    localparam logic [23:0] SYNC_START  = {1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0};

    logic       pixelClockX6;
    logic       nReset;
    logic [2:0] pixelClockPhase;

    logic       hSyncF, vSyncF, deF, oddF;
    logic [9:0] flF, fldF;
    logic       hSyncS, vSyncS, deS, oddS;
    logic [9:0] flS, fldS;
    logic [23:0] actFull, actSmall;

    int checks;
    int failures;
    int cycles;
    int tickIdx;
    logic [23:0] expFull, expSmall, prevFull, prevSmall;

    timingT fullT;
    timingT smallT;

    int hsFallF[$], hsRiseF[$], deRiseF[$], deFallF[$], vsFallF[$], vsRiseF[$], hsAtVsFallF[$];
    int vsFallS[$], hsAtVsFallS[$], oddAtVsFallS[$];

    pi_timing_generator dutFull (
        .pixelClockX6    (pixelClockX6),
        .nReset          (nReset),
        .pixelClockPhase (pixelClockPhase),
        .hSync           (hSyncF),
        .vSync           (vSyncF),
        .displayEnabled  (deF),
        .isFieldOdd      (oddF),
        .fieldLine       (flF),
        .fieldLineDot    (fldF)
    );

    pi_timing_generator #(
        .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(6), .H_ACTIVE(10),
        .V_TOTAL(15), .V_SYNC(2), .ODD_ACT(2), .EVEN_ACT(9), .V_ACTIVE(4)
    ) dutSmall (
        .pixelClockX6    (pixelClockX6),
        .nReset          (nReset),
        .pixelClockPhase (pixelClockPhase),
        .hSync           (hSyncS),
        .vSync           (vSyncS),
        .displayEnabled  (deS),
        .isFieldOdd      (oddS),
        .fieldLine       (flS),
        .fieldLineDot    (fldS)
    );

    assign actFull  = {hSyncF, vSyncF, deF, oddF, flF, fldF};
    assign actSmall = {hSyncS, vSyncS, deS, oddS, flS, fldS};

    initial pixelClockX6 = 1'b0;
    always #5 pixelClockX6 = ~pixelClockX6;

    // Expected outputs for linear frame position p, straight from the timing rules.
    function automatic logic [23:0] expectAt(input timingT t, input int p);
        int lineN, dotN, evenStart, fl, fld;
        logic hs, vs, de, odd, actLine;
        lineN     = p / t.hTot;
        dotN      = p % t.hTot;
        evenStart = t.evenLine * t.hTot + t.evenDot;
        hs        = (dotN >= t.hSync);
        vs        = !((p < t.vSync * t.hTot) ||
                      ((p >= evenStart) && (p < evenStart + t.vSync * t.hTot)));
        odd       = (p < evenStart);
        fl        = 0;
        actLine   = 1'b0;
        if ((lineN >= t.oddAct) && (lineN < t.oddAct + t.vActN)) begin
            actLine = 1'b1;
            fl      = lineN - t.oddAct;
        end else if ((lineN >= t.evenAct) && (lineN < t.evenAct + t.vActN)) begin
            actLine = 1'b1;
            fl      = lineN - t.evenAct;
        end
        de  = actLine && (dotN >= t.hAct) && (dotN < t.hAct + t.hActN);
        fld = de ? (dotN - t.hAct) : 0;
        return {hs, vs, de, odd, 10'(fl), 10'(fld)};
    endfunction

    function automatic int qAt(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at tick %0d: got hs=%b vs=%b de=%b odd=%b line=%0d dot=%0d, required hs=%b vs=%b de=%b odd=%b line=%0d dot=%0d",
                     name, tickIdx, act[23], act[22], act[21], act[20], act[19:10], act[9:0],
                     exp[23], exp[22], exp[21], exp[20], exp[19:10], exp[9:0]);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive the phase, advance the model on ticks, compare both instances.
    task automatic applyStimulus(input logic [2:0] ph);
        logic isTick;
        pixelClockPhase = ph;
        isTick = (ph == 3'd0) && nReset;
        @(posedge pixelClockX6);
        #1;
        cycles++;
        if (isTick) begin
            expFull  = expectAt(fullT, tickIdx % (fullT.hTot * fullT.vTot));
            expSmall = expectAt(smallT, tickIdx % (smallT.hTot * smallT.vTot));
        end
        checkOutput("scoreboard full", actFull, expFull);
        checkOutput("scoreboard small", actSmall, expSmall);
        if (isTick) begin
            if (prevFull[23] && !actFull[23]) hsFallF.push_back(tickIdx);
            if (!prevFull[23] && actFull[23]) hsRiseF.push_back(tickIdx);
            if (!prevFull[21] && actFull[21]) deRiseF.push_back(tickIdx);
            if (prevFull[21] && !actFull[21]) deFallF.push_back(tickIdx);
            if (!prevFull[22] && actFull[22]) vsRiseF.push_back(tickIdx);
            if (prevFull[22] && !actFull[22]) begin
                vsFallF.push_back(tickIdx);
                hsAtVsFallF.push_back(int'(actFull[23]));
            end
            if (prevSmall[22] && !actSmall[22]) begin
                vsFallS.push_back(tickIdx);
                hsAtVsFallS.push_back(int'(actSmall[23]));
                oddAtVsFallS.push_back(int'(actSmall[20]));
            end
            tickIdx++;
        end
        prevFull  = actFull;
        prevSmall = actSmall;
    endtask

    function automatic logic [2:0] randomPhase();
        if ($urandom_range(0, 9) < 7) return 3'd0;
        return 3'($urandom_range(1, 7));
    endfunction

    initial begin
        vectorT vectors [8];
        logic [23:0] snapFull, snapSmall;

        fullT  = '{864, 64, 132, 720, 625, 3, 23, 335, 288, 312, 432};
        smallT = '{20, 3, 6, 10, 15, 2, 2, 9, 4, 7, 10};

        vectors[0] = '{3'd3, RESET_VALUE};
        vectors[1] = '{3'd5, RESET_VALUE};
        vectors[2] = '{3'd0, SYNC_START};
        vectors[3] = '{3'd6, SYNC_START};
        vectors[4] = '{3'd7, SYNC_START};
        vectors[5] = '{3'd0, SYNC_START};
        vectors[6] = '{3'd1, SYNC_START};
        vectors[7] = '{3'd0, SYNC_START};

        checks          = 0;
        failures        = 0;
        cycles          = 0;
        tickIdx         = 0;
        expFull         = RESET_VALUE;
        expSmall        = RESET_VALUE;
        prevFull        = RESET_VALUE;
        prevSmall       = RESET_VALUE;
        nReset          = 1'b0;
        pixelClockPhase = 3'd0;

        $display("[TB] reset held for 20 cycles with random phases");
        for (int i = 0; i < 20; i++) applyStimulus(randomPhase());
        checkValue("reset hSync", int'(hSyncF), 1);
        checkValue("reset vSync", int'(vSyncF), 1);
        checkValue("reset displayEnabled", int'(deF), 0);
        checkValue("reset isFieldOdd", int'(oddF), 0);

        nReset = 1'b1;
        $display("[TB] directed vectors after release");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].phase);
            checkOutput($sformatf("vector %0d", i), actFull, vectors[i].expFull);
        end

        $display("[TB] random-phase free run");
        while ((tickIdx < 21500) && (cycles < 70000)) applyStimulus(randomPhase());

        checkValue("first hSync fall tick", qAt(hsFallF, 0), 0);
        checkValue("hSync low ticks", qAt(hsRiseF, 0) - qAt(hsFallF, 0), 64);
        checkValue("line period ticks", qAt(hsFallF, 1) - qAt(hsFallF, 0), 864);
        checkValue("odd vSync fall hSync level", qAt(hsAtVsFallF, 0), 0);
        checkValue("vSync low ticks", qAt(vsRiseF, 0) - qAt(vsFallF, 0), 2592);
        checkValue("first active dot after vSync fall", qAt(deRiseF, 0) - qAt(vsFallF, 0), 23 * 864 + 132);
        checkValue("DE rise after hSync fall", qAt(deRiseF, 0) - qAt(hsFallF, 23), 132);
        checkValue("DE high ticks", qAt(deFallF, 0) - qAt(deRiseF, 0), 720);
        checkValue("small even vSync offset", qAt(vsFallS, 1) - qAt(vsFallS, 0), 7 * 20 + 10);
        checkValue("small odd vSync hSync level", qAt(hsAtVsFallS, 0), 0);
        checkValue("small even vSync hSync level", qAt(hsAtVsFallS, 1), 1);
        checkValue("small odd vSync isFieldOdd", qAt(oddAtVsFallS, 0), 1);
        checkValue("small even vSync isFieldOdd", qAt(oddAtVsFallS, 1), 0);
        checkValue("small frame period", qAt(vsFallS, 2) - qAt(vsFallS, 0), 300);

        $display("[TB] phase held at 3 for 200 cycles");
        snapFull  = actFull;
        snapSmall = actSmall;
        for (int i = 0; i < 200; i++) applyStimulus(3'd3);
        checkOutput("hold full", actFull, snapFull);
        checkOutput("hold small", actSmall, snapSmall);

        for (int i = 0; i < 37; i++) applyStimulus(3'd0);

        $display("[TB] asynchronous reset mid-field");
        nReset = 1'b0;
        #1;
        expFull  = RESET_VALUE;
        expSmall = RESET_VALUE;
        tickIdx  = 0;
        checkOutput("async reset full", actFull, RESET_VALUE);
        checkOutput("async reset small", actSmall, RESET_VALUE);
        for (int i = 0; i < 4; i++) applyStimulus(3'd0);
        nReset = 1'b1;
        applyStimulus(3'd0);
        checkOutput("restart first tick", actFull, SYNC_START);
        for (int i = 0; i < 100; i++) applyStimulus(randomPhase());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
